// File: rtl/mtsp_sf_exp_np.sv
`default_nettype none
// ============================================================================
// Module   : mtsp_sf_exp_np
// Brief    : Multi-phase exponent special-function unit (LOGB / MANT) with
//            per-phase request holds, round-robin arbitration, 3-stage pipe.
// Revision : 1.0 - initial release
// ============================================================================
module mtsp_sf_exp_np #(
    parameter int PHASES = 2,
    parameter int EXP_W  = 7,
    parameter int FRAC_W = 16,
    parameter int DOUT_W = 32
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic [PHASES-1:0]          REQ_VALID,
    output logic [PHASES-1:0]          REQ_READY,
    input  logic [PHASES-1:0]          REQ_MODE,
    input  logic [PHASES*DOUT_W-1:0]   DIN,
    output logic [PHASES-1:0]          PHASE_EN,
    output logic [$clog2(PHASES)-1:0]  DOUT_PHASE,
    output logic [DOUT_W-1:0]          DOUT
);

    localparam int c_DATA_W = 1 + EXP_W + FRAC_W;
    localparam int c_PW     = $clog2(PHASES);
    localparam int c_KW     = $clog2(EXP_W + 1);
    localparam logic [EXP_W-1:0] c_BIAS   = EXP_W'((1 << (EXP_W - 1)) - 1);
    localparam logic [EXP_W:0]   c_BIAS_X = (EXP_W + 1)'((1 << (EXP_W - 1)) - 1);

    generate
        if (PHASES < 2) begin : g_chk_phases
            $fatal(1, "PHASES must be at least 2");
        end
        if (FRAC_W < EXP_W - 1) begin : g_chk_frac
            $fatal(1, "FRAC_W must be >= EXP_W-1");
        end
        if (DOUT_W < c_DATA_W) begin : g_chk_dout
            $fatal(1, "DOUT_W must be >= 1+EXP_W+FRAC_W");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Hold stage
    // ------------------------------------------------------------------
    logic [c_DATA_W-1:0] r_hold_data [PHASES];
    logic [PHASES-1:0]   r_hold_mode;
    logic [PHASES-1:0]   r_hold_v;
    logic [PHASES-1:0]   w_grant;
    logic [PHASES-1:0]   w_accept;
    logic [c_PW-1:0]     w_gidx;
    logic                w_found;
    logic [c_PW-1:0]     r_ptr;

    assign REQ_READY = nRST ? (~r_hold_v | w_grant) : '0;
    assign w_accept  = REQ_VALID & REQ_READY;

    generate
        for (genvar p = 0; p < PHASES; p++) begin : g_hold
            always_ff @(posedge CLK) begin
                if (!nRST) begin
                    r_hold_data[p] <= '0;
                    r_hold_mode[p] <= 1'b0;
                    r_hold_v[p]    <= 1'b0;
                end else if (w_accept[p]) begin
                    r_hold_data[p] <= DIN[p*DOUT_W +: c_DATA_W];
                    r_hold_mode[p] <= REQ_MODE[p];
                    r_hold_v[p]    <= 1'b1;
                end else if (w_grant[p]) begin
                    r_hold_v[p]    <= 1'b0;
                end
            end

            if (DOUT_W > c_DATA_W) begin : g_pad
                logic w_unused_pad;
                assign w_unused_pad = ^DIN[p*DOUT_W + c_DATA_W +: DOUT_W - c_DATA_W];
            end
        end
    endgenerate

    // Round-robin search begins one past the last granted phase.
    always_comb begin
        w_grant = '0;
        w_gidx  = '0;
        w_found = 1'b0;
        for (int i = 1; i <= PHASES; i++) begin
            if (!w_found && r_hold_v[(int'(r_ptr) + i) % PHASES]) begin
                w_found = 1'b1;
                w_grant[(int'(r_ptr) + i) % PHASES] = 1'b1;
                w_gidx  = c_PW'((int'(r_ptr) + i) % PHASES);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_ptr <= c_PW'(PHASES - 1);
        end else if (w_found) begin
            r_ptr <= w_gidx;
        end
    end

    // ------------------------------------------------------------------
    // S0: granted operand
    // ------------------------------------------------------------------
    logic                r_s0_v;
    logic [c_DATA_W-1:0] r_s0_data;
    logic                r_s0_mode;
    logic [c_PW-1:0]     r_s0_phase;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_s0_v     <= 1'b0;
            r_s0_data  <= '0;
            r_s0_mode  <= 1'b0;
            r_s0_phase <= '0;
        end else begin
            r_s0_v <= w_found;
            if (w_found) begin
                r_s0_data  <= r_hold_data[w_gidx];
                r_s0_mode  <= r_hold_mode[w_gidx];
                r_s0_phase <= w_gidx;
            end
        end
    end

    // ------------------------------------------------------------------
    // S1: unbias exponent, magnitude/sign split, zero detection
    // ------------------------------------------------------------------
    logic [EXP_W-1:0] w_exp;
    logic [EXP_W:0]   w_e;
    logic [EXP_W-1:0] w_abs;
    logic             w_zero;

    assign w_exp  = r_s0_data[FRAC_W +: EXP_W];
    assign w_e    = {1'b0, w_exp} - c_BIAS_X;
    assign w_abs  = EXP_W'(w_e[EXP_W] ? (~w_e + 1'b1) : w_e);
    assign w_zero = (w_exp == '0) | (~r_s0_mode & (w_exp == c_BIAS));

    logic              r_s1_v;
    logic [EXP_W-1:0]  r_s1_abs;
    logic              r_s1_esgn;
    logic              r_s1_mode;
    logic              r_s1_isign;
    logic [FRAC_W-1:0] r_s1_frac;
    logic              r_s1_zero;
    logic [c_PW-1:0]   r_s1_phase;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_s1_v     <= 1'b0;
            r_s1_abs   <= '0;
            r_s1_esgn  <= 1'b0;
            r_s1_mode  <= 1'b0;
            r_s1_isign <= 1'b0;
            r_s1_frac  <= '0;
            r_s1_zero  <= 1'b0;
            r_s1_phase <= '0;
        end else begin
            r_s1_v <= r_s0_v;
            if (r_s0_v) begin
                r_s1_abs   <= w_abs;
                r_s1_esgn  <= w_e[EXP_W];
                r_s1_mode  <= r_s0_mode;
                r_s1_isign <= r_s0_data[c_DATA_W-1];
                r_s1_frac  <= r_s0_data[FRAC_W-1:0];
                r_s1_zero  <= w_zero;
                r_s1_phase <= r_s0_phase;
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: integer-to-float for LOGB, rebias for MANT
    // ------------------------------------------------------------------
    logic [c_KW-1:0]     w_k;
    logic [FRAC_W-1:0]   w_lfrac;
    logic [c_DATA_W-1:0] w_logb;
    logic [c_DATA_W-1:0] w_mant;
    logic [c_DATA_W-1:0] w_res;
    logic [PHASES-1:0]   w_onehot;

    always_comb begin
        w_k = '0;
        for (int i = 0; i < EXP_W; i++) begin
            if (r_s1_abs[i]) begin
                w_k = c_KW'(i);
            end
        end
        // Right-shifting by k parks the leading one at bit FRAC_W, so the
        // low FRAC_W bits are exactly the remaining bits, left-aligned.
        w_lfrac = FRAC_W'({r_s1_abs, {FRAC_W{1'b0}}} >> w_k);
        w_logb  = {r_s1_esgn, c_BIAS + EXP_W'(w_k), w_lfrac};
        w_mant  = {r_s1_isign, c_BIAS, r_s1_frac};
        if (r_s1_zero) begin
            w_res = '0;
        end else if (r_s1_mode) begin
            w_res = w_mant;
        end else begin
            w_res = w_logb;
        end
    end

    assign w_onehot = {{(PHASES-1){1'b0}}, 1'b1} << r_s1_phase;

    logic [PHASES-1:0] r_phase_en;
    logic [c_PW-1:0]   r_dout_phase;
    logic [DOUT_W-1:0] r_dout;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_phase_en   <= '0;
            r_dout_phase <= '0;
            r_dout       <= '0;
        end else begin
            r_phase_en <= r_s1_v ? w_onehot : '0;
            if (r_s1_v) begin
                r_dout_phase <= r_s1_phase;
                r_dout       <= DOUT_W'(w_res);
            end
        end
    end

    assign PHASE_EN   = r_phase_en;
    assign DOUT_PHASE = r_dout_phase;
    assign DOUT       = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_mtsp_sf_exp_np.sv
`default_nettype none
// ============================================================================
// Module   : tb_mtsp_sf_exp_np
// Brief    : Directed self-checking bench for mtsp_sf_exp_np.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mtsp_sf_exp_np;

    localparam int PHASES = 2;
    localparam int EXP_W  = 7;
    localparam int FRAC_W = 16;
    localparam int DOUT_W = 32;

    logic                     clk = 1'b0;
    logic                     n_rst;
    logic [PHASES-1:0]        req_valid;
    logic [PHASES-1:0]        req_ready;
    logic [PHASES-1:0]        req_mode;
    logic [PHASES*DOUT_W-1:0] din;
    logic [PHASES-1:0]        phase_en;
    logic                     dout_phase;
    logic [DOUT_W-1:0]        dout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mtsp_sf_exp_np #(
        .PHASES (PHASES),
        .EXP_W  (EXP_W),
        .FRAC_W (FRAC_W),
        .DOUT_W (DOUT_W)
    ) u_dut (
        .CLK        (clk),
        .nRST       (n_rst),
        .REQ_VALID  (req_valid),
        .REQ_READY  (req_ready),
        .REQ_MODE   (req_mode),
        .DIN        (din),
        .PHASE_EN   (phase_en),
        .DOUT_PHASE (dout_phase),
        .DOUT       (dout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Single uncontended request: result expected 4 cycles after acceptance.
    task automatic send(input int p, input logic mode, input logic [31:0] d,
                        input logic [31:0] exp_v, input string tag);
        req_valid    = 2'b00;
        req_valid[p] = 1'b1;
        req_mode[p]  = mode;
        din[p*DOUT_W +: DOUT_W] = d;
        #1;
        chk({tag, "_ready"}, 32'(req_ready[p]), 32'd1);
        step();
        req_valid = 2'b00;
        for (int i = 1; i <= 3; i++) begin
            chk({tag, "_early_en"}, 32'(phase_en), 32'd0);
            step();
        end
        chk({tag, "_en"}, 32'(phase_en), 32'(2'b01 << p));
        chk({tag, "_dout"}, dout, exp_v);
        chk({tag, "_phase"}, 32'(dout_phase), 32'(p));
        step();
        chk({tag, "_en_once"}, 32'(phase_en), 32'd0);
        chk({tag, "_dout_hold"}, dout, exp_v);
    endtask

    initial begin
        n_rst     = 1'b0;
        req_valid = '0;
        req_mode  = '0;
        din       = '0;

        // Reset state
        step();
        step();
        chk("rst_en", 32'(phase_en), 32'd0);
        chk("rst_dout", dout, 32'd0);
        chk("rst_phase", 32'(dout_phase), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        n_rst = 1'b1;
        #1;
        chk("ready_after_rst", 32'(req_ready), 32'd3);
        step();

        // LOGB
        send(0, 1'b0, 32'h0042_0000, 32'h0040_8000, "logb_8");
        send(1, 1'b0, 32'h003D_0000, 32'h00C0_0000, "logb_q");
        send(1, 1'b0, 32'h003F_0000, 32'h0000_0000, "logb_one");
        send(1, 1'b0, 32'h0000_ABCD, 32'h0000_0000, "logb_e0");
        send(0, 1'b0, 32'h007F_0000, 32'h0045_0000, "logb_max");
        send(1, 1'b0, 32'h0001_0000, 32'h00C4_F000, "logb_min");
        // MANT
        send(0, 1'b1, 32'h0042_4000, 32'h003F_4000, "mant_pos");
        send(1, 1'b1, 32'h00C2_1234, 32'h00BF_1234, "mant_neg");

        // Contention: both phases stream for 4 cycles; pointer favours phase 0.
        req_mode  = 2'b11;
        req_valid = 2'b11;
        din[0 +: 32]  = 32'h0042_0001;
        din[32 +: 32] = 32'h0042_1001;
        #1;
        chk("cont_ready_c0", 32'(req_ready), 32'd3);
        step();
        din[0 +: 32]  = 32'h0042_0002;
        din[32 +: 32] = 32'h0042_1002;
        #1;
        chk("cont_ready_c1", 32'(req_ready), 32'd1);
        chk("cont_en_c1", 32'(phase_en), 32'd0);
        step();
        din[0 +: 32]  = 32'h0042_0003;
        #1;
        chk("cont_ready_c2", 32'(req_ready), 32'd2);
        chk("cont_en_c2", 32'(phase_en), 32'd0);
        step();
        din[32 +: 32] = 32'h0042_1003;
        #1;
        chk("cont_ready_c3", 32'(req_ready), 32'd1);
        chk("cont_en_c3", 32'(phase_en), 32'd0);
        step();
        req_valid = 2'b00;
        chk("cont_en_r0", 32'(phase_en), 32'd1);
        chk("cont_dout_r0", dout, 32'h003F_0001);
        chk("cont_ph_r0", 32'(dout_phase), 32'd0);
        step();
        chk("cont_en_r1", 32'(phase_en), 32'd2);
        chk("cont_dout_r1", dout, 32'h003F_1001);
        chk("cont_ph_r1", 32'(dout_phase), 32'd1);
        step();
        chk("cont_en_r2", 32'(phase_en), 32'd1);
        chk("cont_dout_r2", dout, 32'h003F_0002);
        step();
        chk("cont_en_r3", 32'(phase_en), 32'd2);
        chk("cont_dout_r3", dout, 32'h003F_1002);
        step();
        chk("cont_en_r4", 32'(phase_en), 32'd1);
        chk("cont_dout_r4", dout, 32'h003F_0003);
        step();
        chk("cont_en_done", 32'(phase_en), 32'd0);
        chk("cont_dout_hold", dout, 32'h003F_0003);
        step();
        chk("cont_en_none", 32'(phase_en), 32'd0);

        // Reset mid-operation discards the in-flight request.
        req_mode  = 2'b00;
        req_valid = 2'b01;
        din[0 +: 32] = 32'h0042_0000;
        step();
        req_valid = 2'b00;
        chk("mid_en_c1", 32'(phase_en), 32'd0);
        step();
        n_rst = 1'b0;
        #1;
        chk("mid_ready_rst", 32'(req_ready), 32'd0);
        chk("mid_en_c2", 32'(phase_en), 32'd0);
        step();
        n_rst = 1'b1;
        chk("mid_en_c3", 32'(phase_en), 32'd0);
        chk("mid_dout_c3", dout, 32'd0);
        step();
        chk("mid_en_c4", 32'(phase_en), 32'd0);
        step();
        chk("mid_en_c5", 32'(phase_en), 32'd0);
        step();
        chk("mid_en_c6", 32'(phase_en), 32'd0);

        // Pointer restored by reset: phase 0 wins first, with latency 4.
        req_valid = 2'b11;
        din[0 +: 32]  = 32'h0042_0000;
        din[32 +: 32] = 32'h003D_0000;
        #1;
        chk("post_ready", 32'(req_ready), 32'd3);
        step();
        req_valid = 2'b00;
        for (int i = 1; i <= 3; i++) begin
            chk("post_early_en", 32'(phase_en), 32'd0);
            step();
        end
        chk("post_en0", 32'(phase_en), 32'd1);
        chk("post_dout0", dout, 32'h0040_8000);
        chk("post_ph0", 32'(dout_phase), 32'd0);
        step();
        chk("post_en1", 32'(phase_en), 32'd2);
        chk("post_dout1", dout, 32'h00C0_0000);
        chk("post_ph1", 32'(dout_phase), 32'd1);
        step();
        chk("post_en_done", 32'(phase_en), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
